// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx
// Brief    : Strobed serial receiver (start/data/even-parity/stop) feeding a
//            2-entry valid/ready word buffer with frame-error and overrun flags.
// Revision : 1.0
// ============================================================================
module serial_frame_rx #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              bit_en,
   input  logic              sin,
   output logic [DATA_W-1:0] dout,
   output logic              dout_perr,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              frame_err,
   output logic              overrun,
   input  logic              ovr_clr
);

   localparam int               CNT_W      = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
   localparam int               ENT_W      = DATA_W + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_sreg;
   logic              r_perr;
   logic              r_frame_err;
   logic              r_overrun;

   logic              w_cnt_clr;
   logic              w_shift;
   logic              w_perr_ld;
   logic              w_push;
   logic              w_ferr;

   logic [ENT_W-1:0]  r_mem [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;
   logic              w_pop;
   logic              w_full;
   logic              w_wr;
   logic              w_ovr_set;
   logic [ENT_W-1:0]  w_head;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bit_en) begin
         case (r_state)
            S_IDLE:   if (!sin) w_state_nxt = S_DATA;
            S_DATA:   if (r_cnt == c_CNT_LAST) w_state_nxt = S_PARITY;
            S_PARITY: w_state_nxt = S_STOP;
            S_STOP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_cnt_clr = 1'b0;
      w_shift   = 1'b0;
      w_perr_ld = 1'b0;
      w_push    = 1'b0;
      w_ferr    = 1'b0;
      if (bit_en) begin
         case (r_state)
            S_IDLE:   w_cnt_clr = !sin;
            S_DATA:   w_shift   = 1'b1;
            S_PARITY: w_perr_ld = 1'b1;
            S_STOP: begin
               w_push = sin;
               w_ferr = !sin;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------ datapath
   // Data arrives LSB first, so each new bit enters at the MSB end.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_cnt  <= '0;
         r_sreg <= '0;
         r_perr <= 1'b0;
      end else begin
         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_shift) begin
            r_cnt  <= r_cnt + c_CNT_ONE;
            r_sreg <= {sin, r_sreg[DATA_W-1:1]};
         end
         if (w_perr_ld) begin
            r_perr <= (^r_sreg) ^ sin;
         end
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_ferr;
      end
   end

   // -------------------------------------------------------- word buffer
   assign w_pop     = (r_count != 2'd0) && dout_ready;
   assign w_full    = (r_count == 2'd2);
   assign w_wr      = w_push && (!w_full || w_pop);
   assign w_ovr_set = w_push && w_full && !w_pop;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_perr, r_sreg};
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // A drop in the same edge as a clear wins, so no overrun is ever lost.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_overrun <= 1'b0;
      end else if (w_ovr_set) begin
         r_overrun <= 1'b1;
      end else if (ovr_clr) begin
         r_overrun <= 1'b0;
      end
   end

   assign w_head     = r_mem[r_rd_ptr];
   assign dout_valid = (r_count != 2'd0);
   assign dout       = dout_valid ? w_head[DATA_W-1:0] : '0;
   assign dout_perr  = dout_valid & w_head[DATA_W];
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_rx
// Brief    : Directed plus randomized frames against a queue-based word model.
// Revision : 1.0
// ============================================================================
module tb_serial_frame_rx;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          clr_n = 1'b0;
   logic          bit_en = 1'b0;
   logic          sin = 1'b1;
   logic [DW-1:0] dout;
   logic          dout_perr;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic          frame_err;
   logic          overrun;
   logic          ovr_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   // Driver annotations for the bit sampled on the coming edge.
   logic          stop_now = 1'b0;
   logic          stop_good = 1'b1;
   logic [DW-1:0] stop_word = '0;
   logic          stop_perr = 1'b0;
   logic          rnd_mode = 1'b0;

   // Model: an ordered list of {perr, word}, capacity two.
   logic [DW:0]   m_q[$];
   logic          m_ovr = 1'b0;
   logic          m_ferr = 1'b0;

   serial_frame_rx #(.DATA_W(DW)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .bit_en     (bit_en),
      .sin        (sin),
      .dout       (dout),
      .dout_perr  (dout_perr),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .ovr_clr    (ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         m_q.delete();
         m_ovr  = 1'b0;
         m_ferr = 1'b0;
      end else begin
         logic pop, push, drop;
         pop    = (m_q.size() != 0) && dout_ready;
         push   = stop_now && bit_en && stop_good;
         drop   = push && (m_q.size() == 2) && !pop;
         m_ferr = stop_now && bit_en && !stop_good;
         if (pop) void'(m_q.pop_front());
         if (push && !drop) m_q.push_back({stop_perr, stop_word});
         if (drop) m_ovr = 1'b1;
         else if (ovr_clr) m_ovr = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (clr_n) begin
         chk("model_valid", {31'd0, dout_valid}, {31'd0, m_q.size() != 0});
         if (m_q.size() != 0) begin
            chk("model_dout", {28'd0, dout}, {28'd0, m_q[0][DW-1:0]});
            chk("model_perr", {31'd0, dout_perr}, {31'd0, m_q[0][DW]});
         end
         chk("model_ferr", {31'd0, frame_err}, {31'd0, m_ferr});
         chk("model_ovr", {31'd0, overrun}, {31'd0, m_ovr});
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rnd_mode) begin
            dout_ready = ($urandom_range(0, 3) == 0);
            ovr_clr    = ($urandom_range(0, 15) == 0);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input logic b, input int gap, input logic is_stop,
                           input logic good, input logic [DW-1:0] w, input logic pe);
      for (int g = 0; g < gap; g++) begin
         bit_en = 1'b0;
         sin    = 1'($urandom);
         tick();
      end
      bit_en    = 1'b1;
      sin       = b;
      stop_now  = is_stop;
      stop_good = good;
      stop_word = w;
      stop_perr = pe;
      tick();
      bit_en   = 1'b0;
      stop_now = 1'b0;
      sin      = 1'b1;
   endtask

   task automatic send_frame(input logic [DW-1:0] w, input logic flip, input logic good,
                             input int gap_lo, input int gap_hi);
      logic pbit;
      pbit = (^w) ^ flip;
      send_bit(1'b0, $urandom_range(gap_lo, gap_hi), 1'b0, 1'b1, w, 1'b0);
      for (int i = 0; i < DW; i++) begin
         send_bit(w[i], $urandom_range(gap_lo, gap_hi), 1'b0, 1'b1, w, 1'b0);
      end
      send_bit(pbit, $urandom_range(gap_lo, gap_hi), 1'b0, 1'b1, w, 1'b0);
      send_bit(good, $urandom_range(gap_lo, gap_hi), 1'b1, good, w, flip);
   endtask

   initial begin
      clr_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_valid", {31'd0, dout_valid}, 32'd0);
      chk("rst_dout", {28'd0, dout}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);
      clr_n = 1'b1;
      tick();

      // Good frame 1011: bits 0,1,1,0,1,1,1
      send_frame(4'b1011, 1'b0, 1'b1, 0, 0);
      chk("t2_valid", {31'd0, dout_valid}, 32'd1);
      chk("t2_dout", {28'd0, dout}, 32'hB);
      chk("t2_perr", {31'd0, dout_perr}, 32'd0);
      repeat (3) tick();
      chk("t2_hold", {28'd0, dout}, 32'hB);

      // Async reset mid-DATA with a word still buffered
      send_bit(1'b0, 0, 1'b0, 1'b1, 4'h5, 1'b0);
      send_bit(1'b1, 0, 1'b0, 1'b1, 4'h5, 1'b0);
      send_bit(1'b0, 0, 1'b0, 1'b1, 4'h5, 1'b0);
      #1 clr_n = 1'b0;
      #1;
      chk("t1_valid", {31'd0, dout_valid}, 32'd0);
      chk("t1_dout", {28'd0, dout}, 32'd0);
      chk("t1_perr", {31'd0, dout_perr}, 32'd0);
      chk("t1_ovr", {31'd0, overrun}, 32'd0);
      tick();
      clr_n = 1'b1;
      tick();
      send_frame(4'h6, 1'b0, 1'b1, 0, 0);
      chk("t1_after", {28'd0, dout}, 32'h6);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      chk("t1_popped", {31'd0, dout_valid}, 32'd0);

      // Parity error: bits 0,1,1,0,1,0,1
      send_frame(4'b1011, 1'b1, 1'b1, 0, 0);
      chk("t3_dout", {28'd0, dout}, 32'hB);
      chk("t3_perr", {31'd0, dout_perr}, 32'd1);
      chk("t3_ovr", {31'd0, overrun}, 32'd0);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;

      // Framing error
      send_frame(4'h9, 1'b0, 1'b0, 0, 0);
      chk("t4_ferr", {31'd0, frame_err}, 32'd1);
      chk("t4_valid", {31'd0, dout_valid}, 32'd0);
      tick();
      chk("t4_ferr_end", {31'd0, frame_err}, 32'd0);

      // Overrun: third word dropped
      send_frame(4'h1, 1'b0, 1'b1, 0, 0);
      send_frame(4'h2, 1'b0, 1'b1, 0, 0);
      send_frame(4'h3, 1'b0, 1'b1, 0, 0);
      chk("t5_ovr", {31'd0, overrun}, 32'd1);
      chk("t5_head1", {28'd0, dout}, 32'h1);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      chk("t5_head2", {28'd0, dout}, 32'h2);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      chk("t5_empty", {31'd0, dout_valid}, 32'd0);
      chk("t5_sticky", {31'd0, overrun}, 32'd1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("t5_clr", {31'd0, overrun}, 32'd0);

      // Pop coincident with the third push edge
      send_frame(4'h1, 1'b0, 1'b1, 0, 0);
      send_frame(4'h2, 1'b0, 1'b1, 0, 0);
      send_bit(1'b0, 0, 1'b0, 1'b1, 4'h3, 1'b0);
      for (int i = 0; i < DW; i++) send_bit(i == 0 || i == 1, 0, 1'b0, 1'b1, 4'h3, 1'b0);
      send_bit(1'b0, 0, 1'b0, 1'b1, 4'h3, 1'b0);
      dout_ready = 1'b1;
      send_bit(1'b1, 0, 1'b1, 1'b1, 4'h3, 1'b0);
      dout_ready = 1'b0;
      chk("t5b_ovr", {31'd0, overrun}, 32'd0);
      chk("t5b_head", {28'd0, dout}, 32'h2);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      chk("t5b_third", {28'd0, dout}, 32'h3);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;

      // Sparse strobes: every 4th clock, junk on sin in between
      send_frame(4'hA, 1'b0, 1'b1, 3, 3);
      chk("t6_dout", {28'd0, dout}, 32'hA);
      chk("t6_perr", {31'd0, dout_perr}, 32'd0);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;

      // Randomized traffic
      rnd_mode = 1'b1;
      for (int f = 0; f < 300; f++) begin
         int idle;
         idle = $urandom_range(0, 3);
         for (int k = 0; k < idle; k++) begin
            bit_en = 1'($urandom);
            sin    = 1'b1;
            tick();
         end
         send_frame(DW'($urandom), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 7) != 0), 0, $urandom_range(0, 3));
      end
      rnd_mode   = 1'b0;
      ovr_clr    = 1'b0;
      dout_ready = 1'b1;
      repeat (4) tick();
      chk("drain_valid", {31'd0, dout_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
